d_phy_multilane_receiver: RTL

HS-only D-PHY receiver for N data lanes sharing one HS clock. It finds the SoT sync byte (0xB8) per lane at either DDR bit phase, deframes each lane into bytes and deskews the lanes through small per-lane FIFOs. It emits one lane-aligned word per byte period to the CSI-2 protocol layer. It replaces the single-lane receiver wherever the sensor uses more than one lane.

---
 rtl/d_phy_multilane_receiver_pkg.sv | 32 +++
 rtl/d_phy_lane_deframer.sv | 92 +++++++++
 rtl/d_phy_multilane_receiver.sv | 109 ++++++++++
 3 files changed

// File: rtl/d_phy_multilane_receiver_pkg.sv
// d_phy_pkg: sync byte, lane state and sync matcher shared by the
// multilane HS receiver (tolerant matching: D_PHY_SYNC_ERR_TOLERANT_EN).
package d_phy_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hB8;
  localparam int BYTE_PERIOD = 4;

  typedef enum logic {
    HUNT,
    LOCKED
  } lane_state_t;

  typedef struct packed {
    logic match;
    logic corrected;
  } sync_res_t;

  function automatic sync_res_t sync_match(
    input logic [7:0] b,
    input logic tolerant
  );
    sync_res_t r;
    logic [7:0] d;
    logic one;
    d = b ^ SYNC_BYTE;
    one = (d != 8'd0) && ((d & (d - 8'd1)) == 8'd0);
    r.match = (d == 8'd0) | (tolerant & one);
    r.corrected = tolerant & one;
    return r;
  endfunction

endpackage

// File: rtl/d_phy_lane_deframer.sv
// Per-lane sync hunt, DDR phase lock and byte deframing.
// Tolerant sync matching and sync_corrected under D_PHY_SYNC_ERR_TOLERANT_EN.
module d_phy_lane_deframer
  import d_phy_pkg::*;
(
  input  logic       clock_p,
  input  logic       reset,
  input  logic       clear,
  input  logic       flush,
  input  logic [1:0] lane_bits,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       locked
`ifdef D_PHY_SYNC_ERR_TOLERANT_EN
  ,
  output logic       sync_corrected
`endif
);

`ifdef D_PHY_SYNC_ERR_TOLERANT_EN
  localparam logic TOL = 1'b1;
`else
  localparam logic TOL = 1'b0;
`endif

  lane_state_t state, state_n;
  logic [8:0] sr;
  logic [1:0] cnt, cnt_n;
  logic phase, phase_n;
  sync_res_t r0, r1;
  logic e0, e1, hit;

  always_comb begin
    r0 = sync_match(sr[8:1], TOL);
    r1 = sync_match(sr[7:0], TOL);
  end

  assign e0 = r0.match & ~r0.corrected;
  assign e1 = r1.match & ~r1.corrected;
  assign hit = r0.match | r1.match;

  always_comb begin
    state_n = state;
    cnt_n = cnt;
    phase_n = phase;
    unique case (state)
      HUNT: begin
        if (hit) begin
          state_n = LOCKED;
          cnt_n = 2'(BYTE_PERIOD - 1);
          // exact beats tolerant, phase 0 beats phase 1
          phase_n = ~e0 & (e1 | ~r0.match);
        end
      end
      LOCKED: cnt_n = cnt - 2'd1;
      default: state_n = HUNT;
    endcase
    if (flush) begin
      state_n = HUNT;
      cnt_n = 2'd0;
    end
  end

  always_ff @(posedge clock_p or posedge reset) begin
    if (reset) begin
      sr <= '0;
      state <= HUNT;
      cnt <= 2'd0;
      phase <= 1'b0;
    end else if (clear) begin
      sr <= '0;
      state <= HUNT;
      cnt <= 2'd0;
      phase <= 1'b0;
    end else begin
      sr <= {lane_bits[1], lane_bits[0], sr[8:2]};
      state <= state_n;
      cnt <= cnt_n;
      phase <= phase_n;
    end
  end

  assign locked = (state == LOCKED);
  assign byte_valid = locked && (cnt == 2'd0);
  assign byte_data = phase ? sr[7:0] : sr[8:1];

`ifdef D_PHY_SYNC_ERR_TOLERANT_EN
  assign sync_corrected = (state == HUNT) & hit & ~(e0 | e1)
                        & ~flush & ~clear;
`endif

endmodule

// File: rtl/d_phy_multilane_receiver.sv
// Multilane HS D-PHY receiver: per-lane deframers, deskew FIFOs, word align.
// Optional tolerant sync detect and sync_corrected: D_PHY_SYNC_ERR_TOLERANT_EN.
module d_phy_multilane_receiver
  import d_phy_pkg::*;
#(
  parameter int LANES = 2,
  parameter int SKEW_DEPTH = 4
) (
  input  logic                 clock_p,
  input  logic                 reset,
  input  logic [2*LANES-1:0]   lane_bits,
  input  logic                 clear,
  output logic [8*LANES-1:0]   data,
  output logic                 enable,
  output logic [LANES-1:0]     lane_locked,
  output logic                 skew_error
`ifdef D_PHY_SYNC_ERR_TOLERANT_EN
  ,
  output logic [LANES-1:0]     sync_corrected
`endif
);

  localparam int AW = (SKEW_DEPTH > 1) ? $clog2(SKEW_DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(SKEW_DEPTH);

  logic [7:0] lane_byte [LANES];
  logic [7:0] mem [LANES][SKEW_DEPTH];
  logic [AW-1:0] wr_ptr [LANES];
  logic [AW-1:0] rd_ptr [LANES];
  logic [AW:0] count [LANES];
  logic [LANES-1:0] push, nonempty, full;
  logic pop, overflow;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    d_phy_lane_deframer u_deframer (
      .clock_p       (clock_p),
      .reset         (reset),
      .clear         (clear),
      .flush         (overflow),
      .lane_bits     (lane_bits[2*i+1:2*i]),
      .byte_data     (lane_byte[i]),
      .byte_valid    (push[i]),
      .locked        (lane_locked[i])
`ifdef D_PHY_SYNC_ERR_TOLERANT_EN
      ,
      .sync_corrected(sync_corrected[i])
`endif
    );
    assign nonempty[i] = (count[i] != '0);
    assign full[i] = (count[i] == FULL);
  end

  // pops are all-lanes-at-once, so an overflow can never coincide with one
  assign pop = &nonempty;
  assign overflow = (|(push & full)) & ~pop;

  always_ff @(posedge clock_p) begin
    for (int i = 0; i < LANES; i++) begin
      if (!clear && !overflow && push[i])
        mem[i][wr_ptr[i]] <= lane_byte[i];
    end
  end

  always_ff @(posedge clock_p or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i] <= '0;
      end
      data <= '0;
      enable <= 1'b0;
      skew_error <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < LANES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i] <= '0;
      end
      data <= '0;
      enable <= 1'b0;
      skew_error <= 1'b0;
    end else if (overflow) begin
      for (int i = 0; i < LANES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i] <= '0;
      end
      enable <= 1'b0;
      skew_error <= 1'b1;
    end else begin
      enable <= pop;
      for (int i = 0; i < LANES; i++) begin
        if (push[i])
          wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop) begin
          rd_ptr[i] <= rd_ptr[i] + 1'b1;
          data[8*i +: 8] <= mem[i][rd_ptr[i]];
        end
        unique case ({push[i], pop})
          2'b10: count[i] <= count[i] + 1'b1;
          2'b01: count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

endmodule
